pit_irq_scheduler: RTL and testbench
====================================

PIT_IRQ_SCHEDULER -- requirements
Module: pit_irq_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of timer channels; this revision supports only 4, so all widths below are fixed to it.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 enable  input  1  1 = capture new timer pulses; 0 = ignore irq_in.
REQ-005 irq_in  input  4  one-cycle interrupt pulses, bit i from timer channel i.
REQ-006 mask  input  4  1 = channel i neither captured nor granted.
REQ-007 irq_ack  input  1  host acknowledge of the currently presented interrupt.
REQ-008 overrun_clr  input  1  1 = clear all overrun flags.
REQ-009 irq_out  output  1  registered; 1 = an interrupt is being presented.
REQ-010 irq_id  output  2  registered; channel being presented, valid only while irq_out=1.
REQ-011 pending  output  4  registered pending flags.
REQ-012 overrun  output  4  registered sticky flags, one per channel: a pulse was lost.

Function
REQ-013 Capture: pending[i] shall set on the edge after the cycle where irq_in[i]=1, mask[i]=0 and enable=1.
REQ-014 Pulses with mask[i]=1 or enable=0 shall be dropped: no pending, no overrun.
REQ-015 Overrun: overrun[i] shall set when a capturable pulse arrives on channel i while pending[i]=1 and pending[i] is not being cleared by a grant on that edge.
REQ-016 Clear: overrun_clr=1 shall clear all overrun bits.
REQ-017 Clear vs. set: if overrun_clr=1 and a new overrun set occur in the same cycle, set wins for that bit.
REQ-018 FSM states: IDLE and SERVE.
REQ-019 IDLE, no candidates: the FSM shall stay in IDLE with irq_out=0 when (pending & ~mask) is zero.
REQ-020 IDLE, grant: when (pending & ~mask) is nonzero, the FSM shall grant one candidate, chosen round-robin starting at last_grant+1 mod 4.
REQ-021 Grant edge: on that same edge, state goes to SERVE, irq_out<=1, irq_id<=winner, pending[winner]<=0 and last_grant<=winner.
REQ-022 Grant vs. new pulse: a capturable pulse on the winner in the grant cycle shall set pending[winner] again; set wins over the grant clear, and no overrun is flagged.
REQ-023 SERVE hold: irq_out and irq_id shall hold until irq_ack=1.
REQ-024 SERVE exit: on irq_ack=1, the next edge shall return to IDLE with irq_out=0.
REQ-025 Minimum gap: there shall be at least one IDLE cycle (irq_out=0) between consecutive grants.
REQ-026 Ignored ack: irq_ack in IDLE shall have no effect.
REQ-027 Latency: a pulse in cycle N with the FSM idle and no competitors gives pending=1 at N+1 and irq_out=1 at N+2.
REQ-028 Captures run in parallel: pulse capture and overrun detection shall continue in every state, independent of the FSM.
REQ-029 enable=0 shall not abort a SERVE in progress and shall not clear pending.
REQ-030 Masking a channel shall not clear its pending bit; the channel becomes grantable again when unmasked.
REQ-031 Masking the channel being served shall not abort the presentation.
REQ-032 Simultaneous pulses on several channels in one cycle shall all set pending; grant order follows round-robin.

Reset
REQ-033 While rst=1, asynchronously: state=IDLE, irq_out=0, irq_id=0, pending=0, overrun=0, last_grant=3 (channel 0 has first priority).
REQ-034 Reset asserted mid-SERVE shall drop the presentation and all pending flags; no ack is required afterwards.
REQ-035 The first edge after rst deasserts shall behave as a normal IDLE cycle.

Verification
REQ-036 Single pulse: rst released, enable=1, mask=0, irq_in=0001 for one cycle at N -> pending=0001 at N+1; irq_out=1, irq_id=0, pending=0000 at N+2; irq_ack at N+4 -> irq_out=0 at N+5.
REQ-037 Round-robin: irq_in=1111 in one cycle, ack each grant immediately -> irq_id sequence 0,1,2,3, each grant separated by one irq_out=0 cycle; overrun=0000.
REQ-038 Overrun: pulse ch2, hold off ack so ch2 is granted and then pending again, pulse ch2 twice more -> overrun=0100; overrun_clr=1 for one cycle -> overrun=0000.
REQ-039 Mask/enable: mask=0010, pulse ch1 -> no pending. Separately: pending ch3 set, then mask=1000 -> no grant while masked; mask=0000 -> ch3 granted. Pulse with enable=0 -> ignored.
REQ-040 Async reset: rst pulsed between clock edges mid-SERVE with pending=0110 -> irq_out=0, pending=0000 immediately; after release, a pulse on ch3 together with ch0 -> ch0 granted first.

Source files
------------

// File: rtl/pit_irq_scheduler.sv
// Four-channel timer interrupt scheduler: captures one-cycle timer pulses into
// pending flags, tracks lost pulses, and presents one interrupt at a time round-robin.
module pit_irq_scheduler #(
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         irq_in,
    input  logic [NUM_CH-1:0]         mask,
    input  logic                      irq_ack,
    input  logic                      overrun_clr,
    output logic                      irq_out,
    output logic [$clog2(NUM_CH)-1:0] irq_id,
    output logic [NUM_CH-1:0]         pending,
    output logic [NUM_CH-1:0]         overrun
);

    localparam int ID_W = $clog2(NUM_CH);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_irq_out;
    logic [ID_W-1:0]     r_irq_id;
    logic [ID_W-1:0]     r_last;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_overrun;

    logic [NUM_CH-1:0]   w_cap;
    logic [NUM_CH-1:0]   w_cand;
    logic                w_grant;
    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    logic [NUM_CH-1:0]   w_grant_clr;
    logic [NUM_CH-1:0]   w_ovr_set;

    assign w_cap  = irq_in & ~mask & {NUM_CH{enable}};
    assign w_cand = r_pending & ~mask;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        logic [ID_W-1:0] idx;
        idx      = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = r_last + ID_W'(k);
            if (!w_found && w_cand[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    assign w_grant     = (r_state == IDLE) && w_found;
    assign w_grant_clr = w_grant ? (NUM_CH'(1) << w_winner) : '0;
    // A pulse on the channel being granted this edge re-arms it rather than overrunning.
    assign w_ovr_set   = w_cap & r_pending & ~w_grant_clr;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_grant) w_state_nxt = SERVE;
            SERVE:   if (irq_ack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_out <= 1'b0;
            r_irq_id  <= '0;
            r_last    <= ID_W'(NUM_CH - 1);
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_irq_out <= (w_state_nxt == SERVE);
            if (w_grant) begin
                r_irq_id <= w_winner;
                r_last   <= w_winner;
            end
            r_pending <= (r_pending & ~w_grant_clr) | w_cap;
            r_overrun <= (overrun_clr ? '0 : r_overrun) | w_ovr_set;
        end
    end

    assign irq_out = r_irq_out;
    assign irq_id  = r_irq_id;
    assign pending = r_pending;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_pit_irq_scheduler.sv
// Bench for pit_irq_scheduler: directed scenarios plus randomized traffic checked
// cycle by cycle against a rule-level model of capture, overrun and round-robin grant.
module tb_pit_irq_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] irq_in = '0;
    logic [3:0] mask = '0;
    logic       irq_ack = 1'b0;
    logic       overrun_clr = 1'b0;
    logic       irq_out;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] overrun;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit [3:0] m_pend;
    bit [3:0] m_ovr;
    bit       m_busy;
    int       m_id;
    int       m_last;

    pit_irq_scheduler #(.NUM_CH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .irq_in(irq_in), .mask(mask),
        .irq_ack(irq_ack), .overrun_clr(overrun_clr), .irq_out(irq_out),
        .irq_id(irq_id), .pending(pending), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend = '0; m_ovr = '0; m_busy = 1'b0; m_id = 0; m_last = 3;
    endtask

    // Advance one clock edge; the model evaluates the inputs seen before the edge.
    task automatic cycle();
        bit [3:0] cap, cand, gclr;
        int win;
        cap  = enable ? (irq_in & ~mask) : 4'b0000;
        cand = m_pend & ~mask;
        gclr = '0;
        win  = -1;
        if (!m_busy && cand != 0)
            for (int k = 1; k <= 4; k++)
                if (win < 0 && cand[(m_last + k) % 4]) win = (m_last + k) % 4;
        @(posedge clk);
        if (win >= 0) begin
            gclr[win] = 1'b1; m_busy = 1'b1; m_id = win; m_last = win;
        end else if (m_busy && irq_ack) begin
            m_busy = 1'b0;
        end
        m_ovr  = (overrun_clr ? 4'b0000 : m_ovr) | (cap & m_pend & ~gclr);
        m_pend = (m_pend & ~gclr) | cap;
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; #2; rst = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        int n = 0;
        while ((irq_out || pending != 0) && n < 40) begin
            irq_ack = irq_out;
            cycle();
            irq_ack = 1'b0;
            n++;
        end
        checks++;
        if (n >= 40) begin failures++; $display("FAIL drain_timeout: irq_out=%b pending=%b still busy", irq_out, pending); end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({irq_out, irq_id, pending, overrun} !== 11'b0) begin
            failures++; $display("FAIL reset_state: got out=%b id=%0d pend=%b ovr=%b, want all zero", irq_out, irq_id, pending, overrun);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        cycle();
        checks++;
        if (irq_out !== 1'b0 || pending !== 4'b0000) begin
            failures++; $display("FAIL first_idle: got out=%b pend=%b, want 0 0000", irq_out, pending);
        end
    endtask

    task automatic test_single_pulse();
        irq_in = 4'b0001; cycle(); irq_in = 4'b0000;
        checks++;
        if (pending !== 4'b0001 || irq_out !== 1'b0) begin
            failures++; $display("FAIL single_n1: got pend=%b out=%b, want 0001 0", pending, irq_out);
        end
        cycle();
        checks++;
        if (irq_out !== 1'b1 || irq_id !== 2'd0 || pending !== 4'b0000) begin
            failures++; $display("FAIL single_n2: got out=%b id=%0d pend=%b, want 1 0 0000", irq_out, irq_id, pending);
        end
        cycle(); cycle();
        checks++;
        if (irq_out !== 1'b1 || irq_id !== 2'd0) begin
            failures++; $display("FAIL single_hold: got out=%b id=%0d, want 1 0", irq_out, irq_id);
        end
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        checks++;
        if (irq_out !== 1'b0) begin
            failures++; $display("FAIL single_ack: got out=%b, want 0", irq_out);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        irq_in = 4'b1111; cycle(); irq_in = 4'b0000;
        checks++;
        if (pending !== 4'b1111) begin
            failures++; $display("FAIL rr_capture: got pend=%b, want 1111", pending);
        end
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            while (!irq_out && n < 8) begin cycle(); n++; end
            checks++;
            if (irq_out !== 1'b1 || irq_id !== 2'(k) || n != 1) begin
                failures++; $display("FAIL rr_grant%0d: got out=%b id=%0d gap=%0d, want 1 %0d 1", k, irq_out, irq_id, n, k);
            end
            irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
            checks++;
            if (irq_out !== 1'b0) begin
                failures++; $display("FAIL rr_gap%0d: got out=%b, want 0", k, irq_out);
            end
        end
        checks++;
        if (overrun !== 4'b0000 || pending !== 4'b0000) begin
            failures++; $display("FAIL rr_end: got ovr=%b pend=%b, want 0000 0000", overrun, pending);
        end
    endtask

    task automatic test_overrun();
        irq_in = 4'b0100; cycle(); irq_in = 4'b0000; cycle();
        checks++;
        if (irq_out !== 1'b1 || irq_id !== 2'd2 || pending !== 4'b0000) begin
            failures++; $display("FAIL ovr_grant: got out=%b id=%0d pend=%b, want 1 2 0000", irq_out, irq_id, pending);
        end
        irq_in = 4'b0100; cycle();
        checks++;
        if (pending !== 4'b0100 || overrun !== 4'b0000) begin
            failures++; $display("FAIL ovr_repend: got pend=%b ovr=%b, want 0100 0000", pending, overrun);
        end
        cycle(); irq_in = 4'b0000;
        checks++;
        if (overrun !== 4'b0100) begin
            failures++; $display("FAIL ovr_set: got ovr=%b, want 0100", overrun);
        end
        overrun_clr = 1'b1; irq_in = 4'b0100; cycle(); irq_in = 4'b0000;
        checks++;
        if (overrun !== 4'b0100) begin
            failures++; $display("FAIL ovr_set_wins: got ovr=%b, want 0100", overrun);
        end
        cycle(); overrun_clr = 1'b0;
        checks++;
        if (overrun !== 4'b0000) begin
            failures++; $display("FAIL ovr_clear: got ovr=%b, want 0000", overrun);
        end
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        irq_in = 4'b0100; cycle(); irq_in = 4'b0000;
        checks++;
        if (irq_out !== 1'b1 || irq_id !== 2'd2 || pending !== 4'b0100 || overrun !== 4'b0000) begin
            failures++; $display("FAIL grant_vs_pulse: got out=%b id=%0d pend=%b ovr=%b, want 1 2 0100 0000", irq_out, irq_id, pending, overrun);
        end
        drain();
    endtask

    task automatic test_mask_enable();
        mask = 4'b0010; irq_in = 4'b0010; cycle(); irq_in = 4'b0000; cycle();
        checks++;
        if (pending !== 4'b0000 || overrun !== 4'b0000 || irq_out !== 1'b0) begin
            failures++; $display("FAIL masked_pulse: got pend=%b ovr=%b out=%b, want 0000 0000 0", pending, overrun, irq_out);
        end
        mask = 4'b0000; enable = 1'b0; irq_in = 4'b0001; cycle(); irq_in = 4'b0000; enable = 1'b1;
        checks++;
        if (pending !== 4'b0000) begin
            failures++; $display("FAIL disabled_pulse: got pend=%b, want 0000", pending);
        end
        irq_in = 4'b1000; cycle(); irq_in = 4'b0000; mask = 4'b1000;
        repeat (3) cycle();
        checks++;
        if (irq_out !== 1'b0 || pending !== 4'b1000) begin
            failures++; $display("FAIL mask_hold: got out=%b pend=%b, want 0 1000", irq_out, pending);
        end
        mask = 4'b0000; cycle();
        checks++;
        if (irq_out !== 1'b1 || irq_id !== 2'd3) begin
            failures++; $display("FAIL unmask_grant: got out=%b id=%0d, want 1 3", irq_out, irq_id);
        end
        mask = 4'b1000; enable = 1'b0; cycle(); cycle();
        checks++;
        if (irq_out !== 1'b1 || irq_id !== 2'd3) begin
            failures++; $display("FAIL mask_served: got out=%b id=%0d, want 1 3", irq_out, irq_id);
        end
        mask = 4'b0000; enable = 1'b1;
        drain();
    endtask

    task automatic test_async_reset();
        irq_in = 4'b0111; cycle(); irq_in = 4'b0000; cycle();
        checks++;
        if (irq_out !== 1'b1 || irq_id !== 2'd0 || pending !== 4'b0110) begin
            failures++; $display("FAIL pre_reset: got out=%b id=%0d pend=%b, want 1 0 0110", irq_out, irq_id, pending);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (irq_out !== 1'b0 || pending !== 4'b0000 || overrun !== 4'b0000) begin
            failures++; $display("FAIL async_reset: got out=%b pend=%b ovr=%b, want 0 0000 0000", irq_out, pending, overrun);
        end
        #2 rst = 1'b0;
        model_reset();
        irq_in = 4'b1001; cycle(); irq_in = 4'b0000; cycle();
        checks++;
        if (irq_out !== 1'b1 || irq_id !== 2'd0 || pending !== 4'b1000) begin
            failures++; $display("FAIL post_reset_rr: got out=%b id=%0d pend=%b, want 1 0 1000", irq_out, irq_id, pending);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            irq_in      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            mask        = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            enable      = ($urandom_range(0, 7) != 0);
            irq_ack     = ($urandom_range(0, 2) == 0);
            overrun_clr = ($urandom_range(0, 15) == 0);
            cycle();
            checks++;
            if (irq_out !== m_busy || pending !== m_pend || overrun !== m_ovr ||
                (m_busy && irq_id !== 2'(m_id))) begin
                failures++;
                $display("FAIL random_cyc%0d: got out=%b id=%0d pend=%b ovr=%b, want out=%b id=%0d pend=%b ovr=%b",
                         i, irq_out, irq_id, pending, overrun, m_busy, m_id, m_pend, m_ovr);
            end
        end
        irq_in = '0; mask = '0; enable = 1'b1; irq_ack = 1'b0; overrun_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_pulse();
        test_round_robin();
        test_overrun();
        test_mask_enable();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
